// File: rtl/hit_bundler_if.sv
// Hit bus between the per-sample test unit (R17) and the z-buffer consumer (R18).
// The bench drives through master; the bundler sits on slave.
interface hit_bundler_if #(
    parameter int SIGFIG  = 24,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 3
);
    logic [1:0][SIGFIG-1:0]                    screen_RnnnnS;
    logic [AXIS-1:0][SIGFIG-1:0]               hit_R17S;
    logic [COLORS-1:0][SIGFIG-1:0]             color_R17U;
    logic                                      hit_valid_R17H;
    logic                                      tri_end_R17H;
    logic [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0]  hit_R18S;
    logic [COLORS-1:0][SIGFIG-1:0]             color_R18U;
    logic [SAMPLES-1:0]                        hit_valid_R18H;
    logic [31:0]                               drop_cnt_RnnnnU;
    logic [31:0]                               bundle_cnt_RnnnnU;

    modport master (
        output screen_RnnnnS, hit_R17S, color_R17U, hit_valid_R17H, tri_end_R17H,
        input  hit_R18S, color_R18U, hit_valid_R18H, drop_cnt_RnnnnU, bundle_cnt_RnnnnU
    );

    modport slave (
        input  screen_RnnnnS, hit_R17S, color_R17U, hit_valid_R17H, tri_end_R17H,
        output hit_R18S, color_R18U, hit_valid_R18H, drop_cnt_RnnnnU, bundle_cnt_RnnnnU
    );
endinterface

// File: rtl/hit_bundler.sv
// Drops off-screen hits and packs consecutive same-colour hits into bundles of up to
// SAMPLES slots, emitted as a one-cycle valid pulse with a shared colour.
module hit_bundler #(
    parameter int SIGFIG  = 24,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    hit_bundler_if.slave  bus
);
    localparam int IW = $clog2(SAMPLES);

    typedef logic [SAMPLES-1:0][AXIS-1:0][SIGFIG-1:0] slots_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]            col_t;

    slots_t               slot_q, slot_d, hit_out_q, hit_out_d;
    col_t                 hc_q, hc_d, col_out_q, col_out_d;
    logic [IW-1:0]        cnt_q, cnt_d, cnt_a;
    logic                 pend_q, pend_d;
    logic [SAMPLES-1:0]   valid_out_q, valid_out_d;
    logic [31:0]          drop_q, drop_d, bundle_q, bundle_d;

    logic signed [SIGFIG-1:0] x_pos, y_pos, width, height;
    logic in_bounds, v, dropped, conflict, pre_emit, close;

    assign x_pos  = $signed(bus.hit_R17S[0]);
    assign y_pos  = $signed(bus.hit_R17S[1]);
    assign width  = $signed(bus.screen_RnnnnS[0]);
    assign height = $signed(bus.screen_RnnnnS[1]);

    assign in_bounds = !x_pos[SIGFIG-1] && (x_pos < width) &&
                       !y_pos[SIGFIG-1] && (y_pos < height);
    assign v        = bus.hit_valid_R17H && in_bounds;
    assign dropped  = bus.hit_valid_R17H && !in_bounds;
    assign conflict = v && (cnt_q != '0) && (bus.color_R17U != hc_q);
    // The held bundle leaves first; the incoming hit then starts from slot 0.
    assign pre_emit = pend_q || conflict || (!v && bus.tri_end_R17H && (cnt_q != '0));
    assign cnt_a    = pre_emit ? '0 : cnt_q;
    assign close    = v && ((cnt_a == IW'(SAMPLES-1)) || bus.tri_end_R17H);

    // Next-state and registered-output computation.
    always_comb begin
        slot_d      = slot_q;
        hc_d        = hc_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        hit_out_d   = hit_out_q;
        col_out_d   = col_out_q;
        valid_out_d = '0;
        drop_d      = dropped ? drop_q + 32'd1 : drop_q;
        bundle_d    = bundle_q;

        if (pre_emit) begin
            for (int i = 0; i < SAMPLES; i++) begin
                if (i < int'(cnt_q)) begin
                    hit_out_d[i]   = slot_q[i];
                    valid_out_d[i] = 1'b1;
                end else begin
                    valid_out_d[i] = 1'b0;
                end
            end
            col_out_d = hc_q;
            bundle_d  = bundle_q + 32'd1;
        end else if (close) begin
            // Emit the bundle completed by this very hit without a round trip through slots.
            for (int i = 0; i < SAMPLES; i++) begin
                if (i < int'(cnt_a)) begin
                    hit_out_d[i]   = slot_q[i];
                    valid_out_d[i] = 1'b1;
                end else if (i == int'(cnt_a)) begin
                    hit_out_d[i]   = bus.hit_R17S;
                    valid_out_d[i] = 1'b1;
                end else begin
                    valid_out_d[i] = 1'b0;
                end
            end
            col_out_d = bus.color_R17U;
            bundle_d  = bundle_q + 32'd1;
        end else begin
            valid_out_d = '0;
        end

        if (v) begin
            slot_d[cnt_a] = bus.hit_R17S;
            hc_d          = bus.color_R17U;
            if (close && !pre_emit) begin
                cnt_d = '0;
            end else begin
                cnt_d  = cnt_a + 1'b1;
                pend_d = close;
            end
        end else begin
            cnt_d = cnt_a;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q      <= '0;
            hc_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            hit_out_q   <= '0;
            col_out_q   <= '0;
            valid_out_q <= '0;
            drop_q      <= 32'd0;
            bundle_q    <= 32'd0;
        end else begin
            slot_q      <= slot_d;
            hc_q        <= hc_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            hit_out_q   <= hit_out_d;
            col_out_q   <= col_out_d;
            valid_out_q <= valid_out_d;
            drop_q      <= drop_d;
            bundle_q    <= bundle_d;
        end
    end

    assign bus.hit_R18S          = hit_out_q;
    assign bus.color_R18U        = col_out_q;
    assign bus.hit_valid_R18H    = valid_out_q;
    assign bus.drop_cnt_RnnnnU   = drop_q;
    assign bus.bundle_cnt_RnnnnU = bundle_q;
endmodule

// File: tb/tb_hit_bundler.sv
// Table-driven bench for hit_bundler: each row drives one cycle and may push the bundle
// it should produce onto a scoreboard that the output monitor pops.
module tb_hit_bundler;
    localparam int SIGFIG  = 24;
    localparam int RADIX   = 10;
    localparam int AXIS    = 3;
    localparam int COLORS  = 3;
    localparam int SAMPLES = 3;

    typedef logic [COLORS-1:0][SIGFIG-1:0] col_t;

    typedef struct {
        logic rst; logic hv; logic te;
        int x; int y; int c;
        logic ex; logic [2:0] mask; int e0; int e1; int e2; int ec;
        logic ck;
    } row_t;

    typedef struct {
        int due; logic [2:0] mask; int e0; int e1; int e2; int ec;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hit_bundler_if #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .SAMPLES(SAMPLES)) bus ();

    hit_bundler #(.SIGFIG(SIGFIG), .AXIS(AXIS), .COLORS(COLORS), .SAMPLES(SAMPLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    row_t tbl[$];
    exp_t sb[$];
    int   edge_no    = 0;
    int   n_chk      = 0;
    int   n_fail     = 0;
    int   drop_exp   = 0;
    int   bundle_exp = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    function automatic col_t col_of(input int c);
        col_t r = '0;
        r[c] = 24'hFFF;
        return r;
    endfunction

    function automatic logic [SIGFIG-1:0] fx(input int p);
        return SIGFIG'(p * (1 << RADIX));
    endfunction

    task automatic add(input logic rs, input logic hv, input logic te, input int x, input int y,
                       input int c, input logic ex, input logic [2:0] m,
                       input int e0, input int e1, input int e2, input int ec);
        row_t t;
        t.rst = rs; t.hv = hv; t.te = te; t.x = x; t.y = y; t.c = c;
        t.ex = ex; t.mask = m; t.e0 = e0; t.e1 = e1; t.e2 = e2; t.ec = ec; t.ck = 1'b0;
        tbl.push_back(t);
    endtask

    task automatic mark_ck();
        tbl[tbl.size()-1].ck = 1'b1;
    endtask

    task automatic apply(input row_t t);
        exp_t e;
        @(negedge clk);
        rst                = t.rst;
        bus.hit_valid_R17H = t.hv;
        bus.tri_end_R17H   = t.te;
        bus.hit_R17S[0]    = fx(t.x);
        bus.hit_R17S[1]    = fx(t.y);
        bus.hit_R17S[2]    = fx(t.x + t.y);
        bus.color_R17U     = col_of(t.c);
        if (t.rst) begin
            drop_exp   = 0;
            bundle_exp = 0;
        end else if (t.hv && !(t.x >= 0 && t.x < 640 && t.y >= 0 && t.y < 480)) begin
            drop_exp++;
        end
        if (t.ex) begin
            e.due = edge_no + 1; e.mask = t.mask;
            e.e0 = t.e0; e.e1 = t.e1; e.e2 = t.e2; e.ec = t.ec;
            sb.push_back(e);
            bundle_exp++;
        end
    endtask

    task automatic idle();
        row_t t;
        t = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0, 3'b000, 0, 0, 0, 0, 1'b0};
        apply(t);
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_drop_cnt"}, 128'(bus.drop_cnt_RnnnnU), 128'(drop_exp));
        check({tag, "_bundle_cnt"}, 128'(bus.bundle_cnt_RnnnnU), 128'(bundle_exp));
    endtask

    // Output monitor: every valid pulse must match the oldest expected bundle at its due edge.
    always @(posedge clk) begin
        exp_t e;
        int   xe;
        #1;
        edge_no++;
        while (sb.size() > 0 && sb[0].due < edge_no) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_bundle: nothing at edge %0d, required mask %b", sb[0].due, sb[0].mask);
            void'(sb.pop_front());
        end
        if (bus.hit_valid_R18H != '0) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_bundle: mask %b at edge %0d, required none", bus.hit_valid_R18H, edge_no);
            end else begin
                e = sb.pop_front();
                check("bundle_edge", 128'(edge_no), 128'(e.due));
                check("bundle_mask", 128'(bus.hit_valid_R18H), 128'(e.mask));
                check("bundle_color", 128'(bus.color_R18U), 128'(col_of(e.ec)));
                for (int i = 0; i < SAMPLES; i++) begin
                    xe = (i == 0) ? e.e0 : (i == 1) ? e.e1 : e.e2;
                    if (e.mask[i]) check($sformatf("slot%0d_x", i), 128'(bus.hit_R18S[i][0]), 128'(fx(xe)));
                end
            end
        end
    end

    initial begin
        // Reset mid-bundle: two accepted hits are lost, the later tri_end finds nothing held.
        add(1'b0, 1'b1, 1'b0,  10,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  11,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b1, 1'b0, 1'b0,   0,   0, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b0, 1'b1,   0,   0, 0, 1'b0, 3'b000,  0,   0,  0, 0); mark_ck();
        // Full bundle.
        add(1'b0, 1'b1, 1'b0,  10,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  11,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  12,   5, 0, 1'b1, 3'b111, 10,  11, 12, 0); mark_ck();
        // Colour change, then tri_end without a hit.
        add(1'b0, 1'b1, 1'b0,  20,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  21,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  22,   5, 1, 1'b1, 3'b011, 20,  21,  0, 0);
        add(1'b0, 1'b0, 1'b1,   0,   0, 0, 1'b1, 3'b001, 22,   0,  0, 1); mark_ck();
        // Off-screen drops, a dropped hit carrying tri_end, and in-bounds edges.
        add(1'b0, 1'b1, 1'b0, 640,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  -1,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  30, 480, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b1,  31,   5, 0, 1'b1, 3'b001, 31,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  40,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b1, 700,   5, 0, 1'b1, 3'b001, 40,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,   0,   0, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0, 639, 479, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b0, 1'b1,   0,   0, 0, 1'b1, 3'b011,  0, 639,  0, 0); mark_ck();
        // Conflict and flush on the same edge: B follows via pend_flush, C stays held.
        add(1'b0, 1'b1, 1'b0,  50,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b1,  51,   5, 1, 1'b1, 3'b001, 50,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  52,   5, 1, 1'b1, 3'b001, 51,   0,  0, 1);
        add(1'b0, 1'b0, 1'b1,   0,   0, 0, 1'b1, 3'b001, 52,   0,  0, 1); mark_ck();
        // Conflict against a two-hit bundle with tri_end; pending flush fires on an idle cycle.
        add(1'b0, 1'b1, 1'b0,  60,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b0,  61,   5, 0, 1'b0, 3'b000,  0,   0,  0, 0);
        add(1'b0, 1'b1, 1'b1,  62,   5, 1, 1'b1, 3'b011, 60,  61,  0, 0);
        add(1'b0, 1'b0, 1'b0,   0,   0, 0, 1'b1, 3'b001, 62,   0,  0, 1); mark_ck();
        // Idle tri_end.
        for (int i = 0; i < 5; i++) add(1'b0, 1'b0, 1'b1, 0, 0, 0, 1'b0, 3'b000, 0, 0, 0, 0);
        mark_ck();

        rst                = 1'b1;
        bus.screen_RnnnnS[0] = fx(640);
        bus.screen_RnnnnS[1] = fx(480);
        bus.hit_R17S       = '0;
        bus.color_R17U     = '0;
        bus.hit_valid_R17H = 1'b0;
        bus.tri_end_R17H   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_valid", 128'(bus.hit_valid_R18H), 128'(0));
        check("reset_hit", 128'(bus.hit_R18S), 128'(0));
        check("reset_color", 128'(bus.color_R18U), 128'(0));
        check_counts("reset");

        foreach (tbl[k]) begin
            apply(tbl[k]);
            if (tbl[k].ck) begin
                idle();
                check_counts($sformatf("row%0d", k));
            end
        end

        // Outputs hold their last bundle through non-emit cycles.
        add(1'b0, 1'b1, 1'b0, 70, 7, 2, 1'b0, 3'b000,  0,  0,  0, 2);
        add(1'b0, 1'b1, 1'b0, 71, 8, 2, 1'b0, 3'b000,  0,  0,  0, 2);
        add(1'b0, 1'b1, 1'b0, 72, 9, 2, 1'b1, 3'b111, 70, 71, 72, 2);
        for (int k = tbl.size() - 3; k < tbl.size(); k++) apply(tbl[k]);
        idle();
        idle();
        check("hold_valid", 128'(bus.hit_valid_R18H), 128'(0));
        check("hold_color", 128'(bus.color_R18U), 128'(col_of(2)));
        check("hold_slot2_x", 128'(bus.hit_R18S[2][0]), 128'(fx(72)));
        check("hold_slot1_y", 128'(bus.hit_R18S[1][1]), 128'(fx(8)));
        check_counts("hold");
        idle();
        check("scoreboard_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hit_bundler.md
Name: hit_bundler

Overview:
- Rasterizer stage between the per-sample test unit (one hit/cycle, R17) and the z-buffer consumer (SAMPLES-wide hit bus, R18).
- Discards off-screen hits and groups consecutive same-colour hits into bundles of up to SAMPLES.
- Emits each bundle as a one-cycle valid pulse with a shared colour.
- Keeps drop and bundle statistics for the bench.

Parameters:
SIGFIG, 24, bits in colour and position
RADIX, 10, fraction bits
AXIS, 3, axes per sample (x,y,z)
COLORS, 3, colour channels
SAMPLES, 3, hit slots per output bundle (>=2)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
screen_RnnnnS  input  SIGFIG signed x2  screen width [0], height [1], fixed point
hit_R17S  input  SIGFIG signed x AXIS  incoming sample (x,y,z)
color_R17U  input  SIGFIG x COLORS  incoming sample colour
hit_valid_R17H  input  1  incoming sample is a hit
tri_end_R17H  input  1  last sample of current triangle; forces flush
hit_R18S  output  SIGFIG signed x SAMPLES x AXIS  bundled samples
color_R18U  output  SIGFIG x COLORS  bundle colour
hit_valid_R18H  output  1 x SAMPLES  per-slot valid
drop_cnt_RnnnnU  output  32  off-screen hits discarded
bundle_cnt_RnnnnU  output  32  bundles emitted

Behaviour:
- Reset, sampled at posedge:
  - all outputs and internal slots go to 0.
  - fill count cnt=0 and pend_flush=0.
  - A bundle that was partly filled when reset arrives is discarded.
- In-bounds test (full fixed-point signed compare): 0 <= x < screen[0] and 0 <= y < screen[1].
- v = hit_valid_R17H & in-bounds.
- Dropped hit: hit_valid_R17H & !in-bounds. It increments drop_cnt; tri_end on that cycle still applies.
- Internal state:
  - slot[0..SAMPLES-1];
  - held colour hc;
  - cnt (0..SAMPLES-1 between cycles);
  - pend_flush.
- conflict = v & cnt>0 & color_R17U != hc, compared on all channels.
- Per cycle, in priority order. "emit" means the held bundle is registered to the R18 outputs at this edge.
  1. Pre-emit:
     - Emit if pend_flush, or conflict, or (!v & tri_end & cnt>0).
     - Then cnt=0 and pend_flush=0.
  2. Accept (if v):
     - Write the hit to slot[cnt] (cnt after step 1); hc=color_R17U; cnt++.
     - Full or tri_end, no emit in step 1: the new bundle (including this hit) is emitted now and cnt=0.
     - Full or tri_end, and step 1 already emitted: set pend_flush=1; the new bundle is emitted at the next edge.
  3. tri_end with cnt==0 and !v: no effect.
- Emit writes:
  - hit_R18S[i]=slot[i] for i<n;
  - hit_valid_R18H[i]=(i<n);
  - color_R18U=hc of that bundle;
  - bundle_cnt++.
- Non-emit cycle: all hit_valid_R18H=0. hit_R18S and color_R18U hold their last values.
- Slot i is valid only if slots 0..i-1 are valid (contiguous fill from slot 0).
- Latency:
  - A hit that completes or flushes a bundle is visible at R18 one edge after acceptance.
  - Worst case is two edges, via pend_flush.
  - Partial bundles never time out; they wait for tri_end, a colour change or a fill.
- Counters wrap modulo 2^32.
- No backpressure: the block accepts every cycle.
- Hits are never reordered or duplicated; output order equals input order.

Test Plan:
Setup for all scenarios: SAMPLES=3, screen=(640<<10, 480<<10).
1. Reset mid-bundle:
   - Stimulus: 2 hits accepted, rst=1 for one cycle, then tri_end.
   - Required: no valid output at any point; drop_cnt=0; bundle_cnt=0.
2. Full bundle:
   - Stimulus: 3 consecutive hits, colour (0xFFF,0,0), x=10,11,12 (<<10), y=5<<10.
   - Required: one cycle after the third hit, hit_valid_R18H=3'b111, slot x values 10,11,12, colour 0xFFF/0/0; next cycle valid=000; bundle_cnt=1.
3. Colour change:
   - Stimulus: hits A(red), B(red), C(green), then tri_end with no hit.
   - Required: bundle {A,B} valid=011 colour red, emitted on C's edge; bundle {C} valid=001 colour green one cycle later.
4. Off-screen drop:
   - Stimulus: hits at x=640<<10, x=-1, y=480<<10, plus one valid hit with tri_end.
   - Required: drop_cnt=3; single bundle valid=001 containing the valid hit.
5. Conflict and flush together:
   - Stimulus: bundle {A red}; next cycle hit B green with tri_end=1; next cycle hit C green.
   - Required, per edge:
     - edge 1: {A} red;
     - edge 2: {B} green via pend_flush;
     - C is held in slot 0, cnt=1.
6. Idle tri_end:
   - Stimulus: tri_end with cnt=0 and no hit, repeated 5 cycles.
   - Required: no output valid; counters unchanged.
